// File: rtl/toy_vec_pkg.sv
// Shared FSM state encoding and mode constants for the toy vector pipeline.
package toy_vec_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic MODE_ADD2    = 1'b0;
    localparam logic MODE_STENCIL = 1'b1;

endpackage

// File: rtl/toy_vec_pipe_ctrl.sv
// Job FSM plus the two-stage valid chain; every register holds while stalled.
module toy_vec_pipe_ctrl
    import toy_vec_pkg::*;
#(
    parameter int TRIP_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              start,
    input  logic [TRIP_W-1:0] trip_count,
    input  logic [TRIP_W-1:0] trip,
    input  logic [TRIP_W-1:0] idx,
    output logic              accept,
    output logic              issue,
    output logic              store,
    output logic              finish,
    output logic              busy
);

    state_t state;
    logic   v1;
    logic   v2;
    logic   last;

    assign accept = (state == ST_IDLE) & start & ~stall;
    assign issue  = v1 & ~stall;
    assign store  = v2 & ~stall;
    assign last   = (idx == trip - TRIP_W'(1));
    assign finish = (state == ST_DONE) & ~stall;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            v1    <= 1'b0;
            v2    <= 1'b0;
        end else if (!stall) begin
            v2 <= v1;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (trip_count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            v1    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DRAIN;
                        v1    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!v1 && !v2) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/toy_vec_pipe.sv
// Two-stage vector add / stencil engine: stage 1 issues RAM reads,
// stage 2 sums the returned words and writes RAM c.
module toy_vec_pipe
    import toy_vec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int TRIP_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_controller_waitrequest,
    input  logic              start,
    output logic              finish,
    output logic              busy,
    input  logic              mode,
    input  logic [TRIP_W-1:0] trip_count,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              a_enable,
    output logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_out,
    output logic              b_enable,
    output logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_out,
    output logic              c_enable_a,
    output logic [ADDR_W-1:0] c_address_a,
    input  logic [DATA_W-1:0] c_out_a,
    output logic              c_enable_b,
    output logic              c_write_enable_b,
    output logic [ADDR_W-1:0] c_address_b,
    output logic [DATA_W-1:0] c_in_b
);

    logic              stall;
    logic              accept;
    logic              issue;
    logic              store;
    logic              stencil;
    logic              mode_q;
    logic [TRIP_W-1:0] trip_q;
    logic [TRIP_W-1:0] idx;
    logic [ADDR_W-1:0] idx2;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_c_q;

    assign stall   = memory_controller_waitrequest;
    assign stencil = (mode_q == MODE_STENCIL);

    toy_vec_pipe_ctrl #(
        .TRIP_W(TRIP_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .start     (start),
        .trip_count(trip_count),
        .trip      (trip_q),
        .idx       (idx),
        .accept    (accept),
        .issue     (issue),
        .store     (store),
        .finish    (finish),
        .busy      (busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= 1'b0;
            trip_q   <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            idx      <= '0;
            idx2     <= '0;
        end else if (!stall) begin
            if (accept) begin
                mode_q   <= mode;
                trip_q   <= trip_count;
                base_a_q <= base_a;
                base_b_q <= base_b;
                base_c_q <= base_c;
                idx      <= '0;
            end else if (issue) begin
                idx <= idx + TRIP_W'(1);
            end
            if (issue) idx2 <= ADDR_W'(idx);
        end
    end

    // Stencil reads c[i+1] now; it is only overwritten one issue later.
    always_comb begin
        a_enable         = 1'b0;
        b_enable         = 1'b0;
        c_enable_a       = 1'b0;
        a_address        = '0;
        b_address        = '0;
        c_address_a      = '0;
        c_enable_b       = 1'b0;
        c_write_enable_b = 1'b0;
        c_address_b      = '0;
        c_in_b           = '0;
        if (issue) begin
            a_enable  = 1'b1;
            b_enable  = 1'b1;
            a_address = base_a_q + ADDR_W'(idx);
            b_address = base_b_q + ADDR_W'(idx);
            if (stencil) begin
                c_enable_a  = 1'b1;
                c_address_a = base_c_q + ADDR_W'(idx) + ADDR_W'(1);
            end
        end
        if (store) begin
            c_enable_b       = 1'b1;
            c_write_enable_b = 1'b1;
            c_address_b      = base_c_q + idx2;
            c_in_b           = a_out + b_out;
            if (stencil) c_in_b = a_out + b_out + c_out_a;
        end
    end

endmodule

// File: tb/tb_toy_vec_pipe.sv
// Scoreboard bench for toy_vec_pipe with behavioural synchronous RAMs.
module tb_toy_vec_pipe;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          wait_req;
    logic          start;
    logic          finish;
    logic          busy;
    logic          mode;
    logic [TW-1:0] trip_count;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [AW-1:0] base_c;
    logic          a_enable;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_out;
    logic          b_enable;
    logic [AW-1:0] b_address;
    logic [DW-1:0] b_out;
    logic          c_enable_a;
    logic [AW-1:0] c_address_a;
    logic [DW-1:0] c_out_a;
    logic          c_enable_b;
    logic          c_write_enable_b;
    logic [AW-1:0] c_address_b;
    logic [DW-1:0] c_in_b;

    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];
    logic [DW-1:0] mem_c [1024];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    toy_vec_pipe #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .TRIP_W(TW)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .memory_controller_waitrequest(wait_req),
        .start                        (start),
        .finish                       (finish),
        .busy                         (busy),
        .mode                         (mode),
        .trip_count                   (trip_count),
        .base_a                       (base_a),
        .base_b                       (base_b),
        .base_c                       (base_c),
        .a_enable                     (a_enable),
        .a_address                    (a_address),
        .a_out                        (a_out),
        .b_enable                     (b_enable),
        .b_address                    (b_address),
        .b_out                        (b_out),
        .c_enable_a                   (c_enable_a),
        .c_address_a                  (c_address_a),
        .c_out_a                      (c_out_a),
        .c_enable_b                   (c_enable_b),
        .c_write_enable_b             (c_write_enable_b),
        .c_address_b                  (c_address_b),
        .c_in_b                       (c_in_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_enable) a_out <= mem_a[a_address];
        if (b_enable) b_out <= mem_b[b_address];
        if (c_enable_a) c_out_a <= mem_c[c_address_a];
        if (c_enable_b && c_write_enable_b) mem_c[c_address_b] <= c_in_b;
    end

    task automatic run_job(input logic md, input int n,
                           input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [AW-1:0] bc, input int stall_at,
                           input int stall_len, output int cycles,
                           output int en_seen);
        logic [AW-1:0] ai;
        logic [AW-1:0] bi;
        logic [AW-1:0] ci;
        logic [AW-1:0] cn;
        wr_t e;
        int bad;
        bad = 0;
        en_seen = 0;
        cycles = -1;
        for (int i = 0; i < n; i++) begin
            ai = ba + AW'(i);
            bi = bb + AW'(i);
            ci = bc + AW'(i);
            cn = ci + AW'(1);
            e.addr = ci;
            e.data = mem_a[ai] + mem_b[bi];
            if (md) e.data = e.data + mem_c[cn];
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        mode = md;
        trip_count = TW'(n);
        base_a = ba;
        base_b = bb;
        base_c = bc;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1)
                    $display("FAIL busy_after_start: got %b want 1", busy);
                if (busy !== 1'b1) errors++;
            end
            if (a_enable | b_enable | c_enable_a | c_enable_b) en_seen++;
            if (wait_req && (a_enable | b_enable | c_enable_a |
                             c_enable_b | finish)) bad++;
            if (c_enable_b && c_write_enable_b) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h",
                             c_address_b, c_in_b);
                end else begin
                    e = exp_q.pop_front();
                    if (c_address_b !== e.addr || c_in_b !== e.data) begin
                        errors++;
                        $display("FAIL write: got %0d/%h want %0d/%h",
                                 c_address_b, c_in_b, e.addr, e.data);
                    end
                end
            end
            if (finish === 1'b1) begin
                cycles = k;
                break;
            end
            // Junk on the job inputs must be ignored once the job is running.
            start = (k == 2);
            if (k == 1) begin
                mode = ~md;
                trip_count = TW'($urandom_range(1, 2000));
                base_a = AW'($urandom);
                base_b = AW'($urandom);
                base_c = AW'($urandom);
            end
            wait_req = (stall_len > 0) && (k >= stall_at) &&
                       (k < stall_at + stall_len);
        end
        start = 1'b0;
        wait_req = 1'b0;
        checks++;
        if (cycles < 0) begin
            errors++;
            $display("FAIL finish_timeout: no finish within 300 cycles");
        end
        @(negedge clk);
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL finish_pulse: finish %b busy %b want 0 0",
                     finish, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d left want 0", exp_q.size());
        end
        exp_q.delete();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_outputs: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_req = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        trip_count = '0;
        base_a = '0;
        base_b = '0;
        base_c = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_enable, b_enable, c_enable_a, c_enable_b,
             c_write_enable_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_enables: got %b want 0",
                     {a_enable, b_enable, c_enable_a, c_enable_b,
                      c_write_enable_b});
        end
        checks++;
        if ({a_address, b_address, c_address_a, c_address_b} !== '0 ||
            c_in_b !== '0) begin
            errors++;
            $display("FAIL reset_addr_data: addr %h %h %h %h data %h",
                     a_address, b_address, c_address_a, c_address_b, c_in_b);
        end
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: finish %b busy %b want 0 0",
                     finish, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add2();
        int cyc;
        int en;
        logic [DW-1:0] want;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(10 * (i + 1));
            mem_c[100 + i] = '1;
        end
        run_job(1'b0, 4, 0, 0, 100, 0, 0, cyc, en);
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL add2_latency: got %0d want 7", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            want = DW'(11 * (i + 1));
            checks++;
            if (mem_c[100 + i] !== want) begin
                errors++;
                $display("FAIL add2_c%0d: got %0d want %0d",
                         i, mem_c[100 + i], want);
            end
        end
    endtask

    task automatic test_stencil();
        int cyc;
        int en;
        logic [DW-1:0] want [4];
        want = '{32'd7, 32'd8, 32'd9, 32'd7};
        for (int i = 0; i < 3; i++) begin
            mem_a[10 + i] = 1;
            mem_b[10 + i] = 1;
        end
        mem_c[200] = 0;
        mem_c[201] = 5;
        mem_c[202] = 6;
        mem_c[203] = 7;
        run_job(1'b1, 3, 10, 10, 200, 0, 0, cyc, en);
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("FAIL stencil_latency: got %0d want 6", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_c[200 + i] !== want[i]) begin
                errors++;
                $display("FAIL stencil_c%0d: got %0d want %0d",
                         i, mem_c[200 + i], want[i]);
            end
        end
    endtask

    task automatic test_zero_trip();
        int cyc;
        int en;
        run_job(1'b1, 0, 30, 30, 30, 0, 0, cyc, en);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 1", cyc);
        end
        checks++;
        if (en != 0) begin
            errors++;
            $display("FAIL zero_enables: got %0d cycles want 0", en);
        end
    endtask

    task automatic test_stall();
        int c0;
        int c1;
        int en;
        for (int i = 0; i < 8; i++) begin
            mem_a[20 + i] = DW'(3 * i + 1);
            mem_b[20 + i] = DW'(100 + i);
        end
        run_job(1'b0, 8, 20, 20, 300, 0, 0, c0, en);
        run_job(1'b0, 8, 20, 20, 400, 3, 3, c1, en);
        checks++;
        if (c0 != 11) begin
            errors++;
            $display("FAIL stall_free_latency: got %0d want 11", c0);
        end
        checks++;
        if (c1 != 14) begin
            errors++;
            $display("FAIL stalled_latency: got %0d want 14", c1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_c[400 + i] !== DW'(3 * i + 101 + i)) begin
                errors++;
                $display("FAIL stall_c%0d: got %0d want %0d",
                         i, mem_c[400 + i], 3 * i + 101 + i);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int en;
        logic [AW-1:0] ad;
        for (int i = 0; i < 4; i++) begin
            ad = AW'(1022) + AW'(i);
            mem_a[500 + i] = 32'hFFFF_FFFF;
            mem_b[500 + i] = 1;
            mem_c[ad] = 32'hDEAD_BEEF;
        end
        run_job(1'b0, 4, 500, 500, AW'(1022), 0, 0, cyc, en);
        for (int i = 0; i < 4; i++) begin
            ad = AW'(1022) + AW'(i);
            checks++;
            if (mem_c[ad] !== '0) begin
                errors++;
                $display("FAIL wrap_c%0d: got %h want 0", ad, mem_c[ad]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int writes;
        int changed;
        int cyc;
        int en;
        writes = 0;
        changed = 0;
        for (int i = 0; i < 10; i++) begin
            mem_a[700 + i] = DW'(i);
            mem_b[700 + i] = DW'(i);
            mem_c[600 + i] = 32'hC0DE_0000 + DW'(i);
        end
        @(negedge clk);
        start = 1'b1;
        mode = 1'b0;
        trip_count = 10;
        base_a = 700;
        base_b = 700;
        base_c = 600;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_enable, b_enable, c_enable_b, busy, finish} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0",
                     {a_enable, b_enable, c_enable_b, busy, finish});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            if (c_enable_b) writes++;
        end
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL reset_writes: got %0d want 0", writes);
        end
        for (int i = 2; i < 10; i++)
            if (mem_c[600 + i] !== 32'hC0DE_0000 + DW'(i)) changed++;
        checks++;
        if (changed != 0) begin
            errors++;
            $display("FAIL reset_c_kept: %0d words changed want 0", changed);
        end
        run_job(1'b0, 2, 704, 700, 650, 0, 0, cyc, en);
        checks++;
        if (cyc != 5 || mem_c[650] !== 32'd4 || mem_c[651] !== 32'd6) begin
            errors++;
            $display("FAIL after_reset_job: cyc %0d c %0d %0d want 5 4 6",
                     cyc, mem_c[650], mem_c[651]);
        end
    endtask

    initial begin
        test_reset();
        test_add2();
        test_stencil();
        test_zero_trip();
        test_stall();
        test_wrap();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toy_vec_pipe.md
TOY_VEC_PIPE -- requirements
Module: toy_vec_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning RAM word-address width.
REQ-003 The block SHALL have parameter TRIP_W, default 11, meaning trip-count width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port memory_controller_waitrequest, input, 1, global stall.
REQ-007 The block SHALL have ports start (input, 1) and finish (output, 1): job request and one-cycle done pulse.
REQ-008 The block SHALL have ports busy (output, 1), high whenever the FSM is not IDLE, and mode (input, 1): 0 = add2, 1 = stencil.
REQ-009 The block SHALL have ports trip_count (input, TRIP_W) and base_a, base_b, base_c (input, ADDR_W): word base addresses.
REQ-010 The block SHALL have ports a_enable (output, 1), a_address (output, ADDR_W) and a_out (input, DATA_W): RAM a read port.
REQ-011 The block SHALL have the same read-port set for RAM b (b_*) and for RAM c port A (c_enable_a, c_address_a, c_out_a).
REQ-012 The block SHALL have ports c_enable_b, c_write_enable_b (output, 1), c_address_b (output, ADDR_W) and c_in_b (output, DATA_W): RAM c write port.

Function
REQ-013 The block SHALL compute, for i = 0..N-1 with N = trip_count: mode 0: c[i] = a[i] + b[i]; mode 1: c[i] = a[i] + b[i] + c[i+1], using the c[i+1] value before this job writes it.
REQ-014 The block SHALL sample trip_count, base_a, base_b, base_c and mode into registers on start in IDLE, and SHALL ignore these inputs at all other times.
REQ-015 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-016 FSM transitions SHALL be:
- IDLE->RUN on start with N>0.
- IDLE->DONE on start with N=0.
- RUN->DRAIN in the cycle the last index issues.
- DRAIN->DONE when no stage is valid.
- DONE->IDLE unconditionally.
REQ-017 Stage 1 (issue) SHALL hold index register i.
- Drive a_address = base_a+i, b_address = base_b+i, and c_address_a = base_c+i+1 in mode 1 (0 in mode 0).
- Assert a_enable and b_enable, plus c_enable_a in mode 1, when v1 & ~stall.
- Increment i after each issue.
REQ-018 Stage 2 (write) SHALL take RAM data one cycle after issue.
- Assert c_enable_b = c_write_enable_b = v2 & ~stall.
- Drive c_address_b = base_c + (index registered from stage 1) and c_in_b = a_out + b_out (+ c_out_a in mode 1).
REQ-019 Sum and address arithmetic SHALL wrap modulo 2^DATA_W and 2^ADDR_W respectively; there SHALL be no overflow indication.
REQ-020 Throughput SHALL be one element per cycle; a stall-free job SHALL take N+3 cycles from the start edge to the finish pulse.
REQ-021 While memory_controller_waitrequest is high:
- FSM, i, valid bits and pipeline registers SHALL hold.
- All RAM enables SHALL be 0.
- finish SHALL not assert.
- RAM outputs are held by RAM clock-enable, so no data is lost.
REQ-022 finish SHALL be high for exactly one cycle, in DONE; start in any state other than IDLE SHALL be ignored.
REQ-023 Outputs not being actively driven SHALL be 0: addresses, c_in_b and all enables.

Reset
REQ-024 Asserting reset SHALL immediately force:
- FSM to IDLE.
- v1, v2, i, finish and busy to 0.
- All enables, addresses and c_in_b to 0.
REQ-025 Reset mid-job SHALL abort the job with no further RAM writes; the next start SHALL run a fresh job normally.

Structure
REQ-026 Package toy_vec_pkg SHALL hold the FSM state typedef and the MODE_ADD2/MODE_STENCIL constants.
REQ-027 The valid/stall chain and exit-condition logic SHALL live in sub-module toy_vec_pipe_ctrl; the datapath SHALL stay in toy_vec_pipe.

Verification
REQ-028 Scenario: mode 0, N=4, a={1,2,3,4}, b={10,20,30,40} -> c={11,22,33,44}, finish at cycle 7 after start.
REQ-029 Scenario: mode 1, N=3, a=b={1,1,1}, c_init={0,5,6,7} -> c={7,8,9}, c[3]=7 unchanged.
REQ-030 Scenario: N=0 -> no RAM enable ever asserts, finish pulses one cycle after start.
REQ-031 Scenario: waitrequest high 3 cycles mid-RUN, N=8 -> results equal the stall-free run, finish delayed by exactly 3 cycles.
REQ-032 Scenario: base_c = 2^ADDR_W-2, N=4 -> writes to addresses 1022, 1023, 0, 1 (ADDR_W=10); a=0xFFFFFFFF, b=1 -> c=0.
REQ-033 Scenario: reset asserted at element 2 of N=10 -> no write after the reset edge; a following N=2 job completes correctly.
